video_timing_generator: RTL

- Parametrised, runtime-reprogrammable raster timing generator that drives the VGA output pipeline and the pixel-fetch logic.
- Generalises the fixed 640x480 sync generator with:
  - parametrised counter widths;
  - per-phase timing registers loaded through a shadowed valid/ready handshake and applied only at frame boundaries;
  - programmable sync polarity;
  - line/frame start strobes;
  - an enable/stall input;
  - a parametrised output alignment delay.

---
 rtl/video_timing_pkg.sv | 38 +++
 rtl/timing_axis_fsm.sv | 74 +++++++
 rtl/video_timing_generator.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// Shared phase encoding, 640x480 reset timing and the timing-config record
// used by the raster timing generator.
package video_timing_pkg;

   typedef enum logic [1:0] {
      PH_ACTIVE = 2'd0,
      PH_FRONT  = 2'd1,
      PH_SYNC   = 2'd2,
      PH_BACK   = 2'd3
   } phase_e;

   localparam int unsigned VT_H_ACTIVE = 640;
   localparam int unsigned VT_H_FRONT  = 16;
   localparam int unsigned VT_H_SYNC   = 96;
   localparam int unsigned VT_H_BACK   = 48;
   localparam int unsigned VT_V_ACTIVE = 480;
   localparam int unsigned VT_V_FRONT  = 10;
   localparam int unsigned VT_V_SYNC   = 2;
   localparam int unsigned VT_V_BACK   = 33;

   // Config fields are stored at a fixed width wide enough for any H_W/V_W
   // up to 16; the generator slices them back down to its counter widths.
   localparam int CFG_W = 16;

   typedef struct packed {
      logic [CFG_W-1:0] h_active;
      logic [CFG_W-1:0] h_front;
      logic [CFG_W-1:0] h_sync;
      logic [CFG_W-1:0] h_back;
      logic [CFG_W-1:0] v_active;
      logic [CFG_W-1:0] v_front;
      logic [CFG_W-1:0] v_sync;
      logic [CFG_W-1:0] v_back;
      logic             h_pol;
      logic             v_pol;
   } timing_cfg_t;

endpackage

// File: rtl/timing_axis_fsm.sv
// One raster axis: walks ACTIVE -> FRONT -> SYNC -> BACK, counting 0..len-1 in
// each phase; wrap_o flags the step that leaves BACK.
module timing_axis_fsm
   import video_timing_pkg::*;
#(
   parameter int W = 12
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         step_i,
   input  logic [W-1:0] len_active_i,
   input  logic [W-1:0] len_front_i,
   input  logic [W-1:0] len_sync_i,
   input  logic [W-1:0] len_back_i,
   output logic [1:0]   state_o,
   output logic [W-1:0] count_o,
   output logic         wrap_o
);

   phase_e       state_q, state_d;
   logic [W-1:0] count_q, count_d;
   logic [W-1:0] len_cur;
   logic [W-1:0] last_cnt;
   logic         at_last;

   always_comb begin
      len_cur = len_active_i;
      case (state_q)
         PH_ACTIVE: len_cur = len_active_i;
         PH_FRONT:  len_cur = len_front_i;
         PH_SYNC:   len_cur = len_sync_i;
         PH_BACK:   len_cur = len_back_i;
      endcase
   end

   // A zero length behaves as one so no phase is ever skipped.
   assign last_cnt = (len_cur == '0) ? '0 : len_cur - W'(1);
   assign at_last  = (count_q == last_cnt);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= PH_ACTIVE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      if (step_i) begin
         if (at_last) begin
            count_d = '0;
            case (state_q)
               PH_ACTIVE: state_d = PH_FRONT;
               PH_FRONT:  state_d = PH_SYNC;
               PH_SYNC:   state_d = PH_BACK;
               PH_BACK:   state_d = PH_ACTIVE;
            endcase
         end else begin
            count_d = count_q + W'(1);
         end
      end
   end

   always_comb begin
      state_o = state_q;
      count_o = count_q;
      wrap_o  = step_i && at_last && (state_q == PH_BACK);
   end

endmodule

// File: rtl/video_timing_generator.sv
// Runtime-reprogrammable raster timing generator: shadowed config applied at
// frame boundaries, programmable sync polarity and a PIPE_DELAY output pipe.
module video_timing_generator
   import video_timing_pkg::*;
#(
   parameter int          H_W          = 12,
   parameter int          V_W          = 11,
   parameter int          PIPE_DELAY   = 1,
   parameter int unsigned DEF_H_ACTIVE = VT_H_ACTIVE,
   parameter int unsigned DEF_H_FRONT  = VT_H_FRONT,
   parameter int unsigned DEF_H_SYNC   = VT_H_SYNC,
   parameter int unsigned DEF_H_BACK   = VT_H_BACK,
   parameter int unsigned DEF_V_ACTIVE = VT_V_ACTIVE,
   parameter int unsigned DEF_V_FRONT  = VT_V_FRONT,
   parameter int unsigned DEF_V_SYNC   = VT_V_SYNC,
   parameter int unsigned DEF_V_BACK   = VT_V_BACK,
   parameter logic        DEF_H_POL    = 1'b0,
   parameter logic        DEF_V_POL    = 1'b0
) (
   input  logic           in_vga_clk,
   input  logic           in_reset,
   input  logic           in_enable,
   input  logic           in_cfg_valid,
   output logic           out_cfg_ready,
   input  logic [H_W-1:0] in_cfg_h_active,
   input  logic [H_W-1:0] in_cfg_h_front,
   input  logic [H_W-1:0] in_cfg_h_sync,
   input  logic [H_W-1:0] in_cfg_h_back,
   input  logic [V_W-1:0] in_cfg_v_active,
   input  logic [V_W-1:0] in_cfg_v_front,
   input  logic [V_W-1:0] in_cfg_v_sync,
   input  logic [V_W-1:0] in_cfg_v_back,
   input  logic           in_cfg_h_pol,
   input  logic           in_cfg_v_pol,
   output logic [H_W-1:0] out_pixel_x,
   output logic [V_W-1:0] out_pixel_y,
   output logic           out_blank_n,
   output logic           out_h_sync,
   output logic           out_v_sync,
   output logic           out_line_start,
   output logic           out_frame_start
);

   localparam int OUT_W = H_W + V_W + 5;

   localparam timing_cfg_t DEF_CFG = '{
      h_active: CFG_W'(DEF_H_ACTIVE),
      h_front:  CFG_W'(DEF_H_FRONT),
      h_sync:   CFG_W'(DEF_H_SYNC),
      h_back:   CFG_W'(DEF_H_BACK),
      v_active: CFG_W'(DEF_V_ACTIVE),
      v_front:  CFG_W'(DEF_V_FRONT),
      v_sync:   CFG_W'(DEF_V_SYNC),
      v_back:   CFG_W'(DEF_V_BACK),
      h_pol:    DEF_H_POL,
      v_pol:    DEF_V_POL
   };

   localparam logic [OUT_W-1:0] RST_VEC =
      {H_W'(0), V_W'(0), 1'b0, ~DEF_H_POL, ~DEF_V_POL, 1'b0, 1'b0};

   timing_cfg_t    active_q, active_d;
   timing_cfg_t    shadow_q, shadow_d;
   timing_cfg_t    cfg_in;
   logic           pending_q, pending_d;
   logic           capture;

   logic [1:0]     h_state, v_state;
   logic [H_W-1:0] h_count;
   logic [V_W-1:0] v_count;
   logic           h_wrap, v_wrap;

   logic [H_W-1:0] pix_x;
   logic [V_W-1:0] pix_y;
   logic           h_act, v_act, blank_n, h_sync, v_sync, line_start, frame_start;
   logic [OUT_W-1:0] stage_in, pipe_out;

   assign cfg_in = '{
      h_active: CFG_W'(in_cfg_h_active),
      h_front:  CFG_W'(in_cfg_h_front),
      h_sync:   CFG_W'(in_cfg_h_sync),
      h_back:   CFG_W'(in_cfg_h_back),
      v_active: CFG_W'(in_cfg_v_active),
      v_front:  CFG_W'(in_cfg_v_front),
      v_sync:   CFG_W'(in_cfg_v_sync),
      v_back:   CFG_W'(in_cfg_v_back),
      h_pol:    in_cfg_h_pol,
      v_pol:    in_cfg_v_pol
   };

   assign capture       = in_cfg_valid && !pending_q;
   assign out_cfg_ready = !pending_q;

   // Capture needs pending clear and apply needs it set, so a write landing on
   // the frame boundary waits for the next boundary.
   always_comb begin
      active_d  = active_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      if (v_wrap && pending_q) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end
      if (capture) begin
         shadow_d  = cfg_in;
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge in_vga_clk or posedge in_reset) begin
      if (in_reset) begin
         active_q  <= DEF_CFG;
         shadow_q  <= DEF_CFG;
         pending_q <= 1'b0;
      end else begin
         active_q  <= active_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
      end
   end

   timing_axis_fsm #(.W(H_W)) u_h_axis (
      .clk_i        (in_vga_clk),
      .rst_i        (in_reset),
      .step_i       (in_enable),
      .len_active_i (active_q.h_active[H_W-1:0]),
      .len_front_i  (active_q.h_front[H_W-1:0]),
      .len_sync_i   (active_q.h_sync[H_W-1:0]),
      .len_back_i   (active_q.h_back[H_W-1:0]),
      .state_o      (h_state),
      .count_o      (h_count),
      .wrap_o       (h_wrap)
   );

   timing_axis_fsm #(.W(V_W)) u_v_axis (
      .clk_i        (in_vga_clk),
      .rst_i        (in_reset),
      .step_i       (h_wrap),
      .len_active_i (active_q.v_active[V_W-1:0]),
      .len_front_i  (active_q.v_front[V_W-1:0]),
      .len_sync_i   (active_q.v_sync[V_W-1:0]),
      .len_back_i   (active_q.v_back[V_W-1:0]),
      .state_o      (v_state),
      .count_o      (v_count),
      .wrap_o       (v_wrap)
   );

   always_comb begin
      h_act       = (h_state == PH_ACTIVE);
      v_act       = (v_state == PH_ACTIVE);
      pix_x       = h_act ? h_count : '0;
      pix_y       = v_act ? v_count : '0;
      blank_n     = h_act && v_act;
      h_sync      = (h_state == PH_SYNC) ? active_q.h_pol : ~active_q.h_pol;
      v_sync      = (v_state == PH_SYNC) ? active_q.v_pol : ~active_q.v_pol;
      line_start  = h_act && (h_count == '0);
      frame_start = line_start && v_act && (v_count == '0);
   end

   assign stage_in = {pix_x, pix_y, blank_n, h_sync, v_sync, line_start, frame_start};

   // Output alignment pipe keeps running while the counters are stalled.
   for (genvar gi = 0; gi < PIPE_DELAY; gi++) begin : g_pipe
      logic [OUT_W-1:0] stage_q;
      if (gi == 0) begin : g_first
         always_ff @(posedge in_vga_clk or posedge in_reset) begin
            if (in_reset) stage_q <= RST_VEC;
            else          stage_q <= stage_in;
         end
      end else begin : g_next
         always_ff @(posedge in_vga_clk or posedge in_reset) begin
            if (in_reset) stage_q <= RST_VEC;
            else          stage_q <= g_pipe[gi-1].stage_q;
         end
      end
   end

   assign pipe_out = g_pipe[PIPE_DELAY-1].stage_q;

   assign {out_pixel_x, out_pixel_y, out_blank_n, out_h_sync, out_v_sync,
           out_line_start, out_frame_start} = pipe_out;

endmodule
